// File: rtl/instr_fetch_if.sv
// Fetch controller bus: control inputs, ROM address/data and the decoder-facing
// valid/ready instruction stream.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              halt;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              busy;

    modport master (
        input  start, halt, branch_en, branch_addr, rom_q, instr_ready,
        output rom_addr, instr, instr_pc, instr_valid, busy
    );

    modport slave (
        output start, halt, branch_en, branch_addr, rom_q, instr_ready,
        input  rom_addr, instr, instr_pc, instr_valid, busy
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a ROM with a registered output: owns the PC, tracks one
// in-flight read and buffers returned words in a 2-entry FIFO.
module instr_fetch_ctrl #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LAST_ADDR = 127
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] buf_data_q [2];
    logic [ADDR_W-1:0] buf_pc_q [2];

    logic pop;
    logic push;
    logic room;
    logic issue;

    assign pop  = (count_q != 2'd0) && bus.instr_ready;
    // A word returning after a branch edge belongs to the flushed stream.
    assign push = inflight_q && !bus.branch_en;
    assign room = (({1'b0, count_q} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;
    assign issue = (state_q == StRun) && !bus.halt && !bus.branch_en && room;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        count_d       = (count_q + {1'b0, push}) - {1'b0, pop};
        rd_ptr_d      = rd_ptr_q ^ pop;
        wr_ptr_d      = wr_ptr_q ^ push;

        if (issue) begin
            pc_d = (pc_q == LastPc) ? '0 : pc_q + 1'b1;
        end

        if (bus.branch_en) begin
            pc_d       = bus.branch_addr;
            inflight_d = 1'b0;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StRun;
            end
            StRun: begin
                if (bus.halt) state_d = bus.branch_en ? StIdle : StDrain;
            end
            StDrain: begin
                if (count_d == 2'd0 && !inflight_d) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_pc_q[0]   <= '0;
            buf_pc_q[1]   <= '0;
        end else if (push) begin
            buf_data_q[wr_ptr_q] <= bus.rom_q;
            buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.instr       = buf_data_q[rd_ptr_q];
    assign bus.instr_pc    = buf_pc_q[rd_ptr_q];
    assign bus.instr_valid = (count_q != 2'd0);
    assign bus.busy        = (state_q != StIdle);
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: ROM model, stream-level reference model checked on
// every falling edge, and directed scenarios with literal expectations.
module tb_instr_fetch_ctrl;
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 16'h1234 ^ (16'(a) * 16'd257);
    endfunction

    always_ff @(posedge clk) bus.rom_q <= rom_word(bus.rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream model: the next word delivered must be exp_pc; only accepts and branches move it.
    logic [AW-1:0] exp_pc = '0;
    int            acc_q[$];
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_instr = '0;
    logic [AW-1:0] prev_pc = '0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_valid", 32'(bus.instr_valid), 32'd0);
            check("rst_addr", 32'(bus.rom_addr), 32'd0);
            exp_pc    = '0;
            prev_hold = 1'b0;
        end else begin
            if (bus.instr_valid) begin
                check("head_pc", 32'(bus.instr_pc), 32'(exp_pc));
                check("head_data", 32'(bus.instr), 32'(rom_word(bus.instr_pc)));
            end
            if (!bus.busy) begin
                check("idle_empty", 32'(bus.instr_valid), 32'd0);
                check("idle_pc", 32'(bus.rom_addr), 32'(exp_pc));
            end
            if (prev_hold) begin
                check("hold_instr", 32'(bus.instr), 32'(prev_instr));
                check("hold_pc", 32'(bus.instr_pc), 32'(prev_pc));
            end
            prev_hold  = bus.instr_valid && !bus.instr_ready && !bus.branch_en;
            prev_instr = bus.instr;
            prev_pc    = bus.instr_pc;
            if (bus.instr_valid && bus.instr_ready) acc_q.push_back(int'(bus.instr_pc));
            if (bus.branch_en) exp_pc = bus.branch_addr;
            else if (bus.instr_valid && bus.instr_ready)
                exp_pc = (exp_pc == 7'd127) ? 7'd0 : exp_pc + 7'd1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t3_exp[10];
        t3_exp = '{120, 121, 122, 123, 124, 125, 126, 127, 0, 1};
        bus.start       = 1'b0;
        bus.halt        = 1'b0;
        bus.branch_en   = 1'b0;
        bus.branch_addr = '0;
        bus.instr_ready = 1'b0;

        // 1: reset, start, latency and first words
        #53 rst_n = 1'b1;
        tick();
        bus.instr_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_valid_e0", 32'(bus.instr_valid), 32'd0);
        check("t1_addr_e0", 32'(bus.rom_addr), 32'd0);
        tick();
        check("t1_valid_e1", 32'(bus.instr_valid), 32'd0);
        check("t1_addr_e1", 32'(bus.rom_addr), 32'd1);
        tick();
        check("t1_valid_e2", 32'(bus.instr_valid), 32'd1);
        check("t1_pc_e2", 32'(bus.instr_pc), 32'd0);
        check("t1_data_e2", 32'(bus.instr), 32'h1234);
        check("t1_addr_e2", 32'(bus.rom_addr), 32'd2);
        tick();
        check("t1_pc_e3", 32'(bus.instr_pc), 32'd1);
        check("t1_data_e3", 32'(bus.instr), 32'h1335);

        // 2: stall at PC 10, then release
        for (int i = 0; i < 40 && !(bus.instr_valid && bus.instr_pc == 7'd10); i++) tick();
        check("t2_reach", 32'(bus.instr_pc), 32'd10);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_valid", 32'(bus.instr_valid), 32'd1);
            check("t2_stall_pc", 32'(bus.instr_pc), 32'd10);
            check("t2_stall_addr", 32'(bus.rom_addr), 32'd12);
        end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_resume_valid", 32'(bus.instr_valid), 32'd1);
            check("t2_resume_pc", 32'(bus.instr_pc), 32'(11 + i));
        end

        // 3: branch to 120 in RUN, wrap past 127
        bus.branch_addr = 7'd120;
        bus.branch_en = 1'b1;
        tick();
        bus.branch_en = 1'b0;
        check("t3_flush_v0", 32'(bus.instr_valid), 32'd0);
        check("t3_flush_addr0", 32'(bus.rom_addr), 32'd120);
        tick();
        check("t3_flush_v1", 32'(bus.instr_valid), 32'd0);
        check("t3_flush_addr1", 32'(bus.rom_addr), 32'd121);
        tick();
        check("t3_first_valid", 32'(bus.instr_valid), 32'd1);
        check("t3_first_pc", 32'(bus.instr_pc), 32'd120);
        acc_q.delete();
        for (int i = 0; i < 40 && acc_q.size() < 10; i++) tick();
        check("t3_count", 32'(acc_q.size() >= 10), 32'd1);
        for (int i = 0; i < 10; i++)
            if (i < acc_q.size()) check("t3_seq", 32'(acc_q[i]), 32'(t3_exp[i]));

        // 4: halt right after 40 issued, drain, resume at 41
        for (int i = 0; i < 200 && bus.rom_addr != 7'd41; i++) tick();
        check("t4_reach", 32'(bus.rom_addr), 32'd41);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("t4_drain_busy", 32'(bus.busy), 32'd1);
        check("t4_drain_pc", 32'(bus.instr_pc), 32'd40);
        check("t4_drain_addr", 32'(bus.rom_addr), 32'd41);
        tick();
        check("t4_idle_busy", 32'(bus.busy), 32'd0);
        check("t4_idle_valid", 32'(bus.instr_valid), 32'd0);
        check("t4_idle_addr", 32'(bus.rom_addr), 32'd41);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("t4_resume_valid", 32'(bus.instr_valid), 32'd1);
        check("t4_resume_pc", 32'(bus.instr_pc), 32'd41);

        // 5: branch in IDLE sets start address; branch+halt in RUN goes straight to IDLE
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        for (int i = 0; i < 10 && bus.busy; i++) tick();
        check("t5_idle", 32'(bus.busy), 32'd0);
        bus.branch_addr = 7'd64;
        bus.branch_en = 1'b1;
        tick();
        bus.branch_en = 1'b0;
        check("t5_idle_busy", 32'(bus.busy), 32'd0);
        check("t5_idle_addr", 32'(bus.rom_addr), 32'd64);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("t5_first_valid", 32'(bus.instr_valid), 32'd1);
        check("t5_first_pc", 32'(bus.instr_pc), 32'd64);
        tick();
        bus.branch_addr = 7'd5;
        bus.branch_en = 1'b1;
        bus.halt = 1'b1;
        tick();
        bus.branch_en = 1'b0;
        bus.halt = 1'b0;
        check("t5_bh_busy", 32'(bus.busy), 32'd0);
        check("t5_bh_valid", 32'(bus.instr_valid), 32'd0);
        check("t5_bh_addr", 32'(bus.rom_addr), 32'd5);
        tick();
        check("t5_bh_valid2", 32'(bus.instr_valid), 32'd0);

        // 6: asynchronous reset during a stall
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t6_stalled", 32'(bus.instr_valid), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_addr", 32'(bus.rom_addr), 32'd0);
        check("t6_rst_pc", 32'(bus.instr_pc), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        bus.instr_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("t6_restart_valid", 32'(bus.instr_valid), 32'd1);
        check("t6_restart_pc", 32'(bus.instr_pc), 32'd0);
        check("t6_restart_data", 32'(bus.instr), 32'h1234);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
